// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
// The stage record is sized for the widest supported adder; narrower builds leave upper bits zero.
package cla_pkg;

    localparam int CLA_GROUP_W   = 4;
    localparam int CLA_MAX_WIDTH = 256;

    function automatic int cla_num_groups(input int width);
        return width / CLA_GROUP_W;
    endfunction

    typedef struct packed {
        logic                     valid;
        logic [CLA_MAX_WIDTH-1:0] sum;
        logic [CLA_MAX_WIDTH-1:0] a;
        logic [CLA_MAX_WIDTH-1:0] b;
        logic                     carry;
        logic                     msb_cin;
        logic                     sub;
    } cla_stage_t;

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group: two-level SOP carries from the group carry-in.
// Also exports group propagate/generate for callers that want a higher lookahead level.
module cla_group4
    import cla_pkg::*;
(
    input  logic [CLA_GROUP_W-1:0] a,
    input  logic [CLA_GROUP_W-1:0] b,
    input  logic                   ci,
    output logic [CLA_GROUP_W-1:0] s,
    output logic                   co,
    output logic                   c3,
    output logic                   p,
    output logic                   g
);

    logic [CLA_GROUP_W-1:0] gi;
    logic [CLA_GROUP_W-1:0] pi;
    logic                   c1;
    logic                   c2;

    assign gi = a & b;
    assign pi = a ^ b;

    assign c1 = gi[0] | (pi[0] & ci);
    assign c2 = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
    assign c3 = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & ci);

    assign g  = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
              | (pi[3] & pi[2] & pi[1] & gi[0]);
    assign p  = &pi;
    assign co = g | (p & ci);

    assign s  = pi ^ {c3, c2, c1, ci};

endmodule

// File: rtl/pipelined_cla_adder.sv
// WIDTH-bit adder resolving one 4-bit lookahead group per pipeline stage, valid/ready streamed.
// Define CLA_SUB_EN to add the sub port (a - b with carry-in forced to 1).
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int OUT_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef CLA_SUB_EN
    ,
    input  logic             sub
`endif
);

    localparam int NG = cla_num_groups(WIDTH);
    localparam int NR = (OUT_REG != 0) ? NG : NG - 1;

    if (WIDTH < CLA_GROUP_W || (WIDTH % CLA_GROUP_W) != 0 || WIDTH > CLA_MAX_WIDTH) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a multiple of 4 between 4 and CLA_MAX_WIDTH");
    end
    if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_out_reg
        $error("pipelined_cla_adder: OUT_REG must be 0 or 1");
    end

    // src[k] feeds group k; src[NG] is what the output ports present.
    cla_stage_t src [NG+1];
    cla_stage_t src0;
    logic       adv;
    logic       sub_eff;
    logic       stage_unused;

`ifdef CLA_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    always_comb begin
        src0               = '0;
        src0.valid         = in_valid;
        src0.a[WIDTH-1:0]  = a;
        src0.b[WIDTH-1:0]  = sub_eff ? ~b : b;
        src0.carry         = sub_eff | cin;
        src0.sub           = sub_eff;
    end

    assign src[0] = src0;

    for (genvar k = 0; k < NG; k++) begin : g_stage
        logic [CLA_GROUP_W-1:0] s;
        logic                   co;
        logic                   c3;
        logic                   grp_p_unused;
        logic                   grp_g_unused;
        cla_stage_t             r;

        cla_group4 u_group (
            .a  (src[k].a[CLA_GROUP_W*k +: CLA_GROUP_W]),
            .b  (src[k].b[CLA_GROUP_W*k +: CLA_GROUP_W]),
            .ci (src[k].carry),
            .s  (s),
            .co (co),
            .c3 (c3),
            .p  (grp_p_unused),
            .g  (grp_g_unused)
        );

        always_comb begin
            r                                   = src[k];
            r.sum[CLA_GROUP_W*k +: CLA_GROUP_W] = s;
            r.carry                             = co;
            r.msb_cin                           = c3;
        end

        if (k < NR) begin : g_reg
            cla_stage_t q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (adv) begin
                    q <= r;
                end
            end

            assign src[k+1] = q;
        end else begin : g_comb
            assign src[k+1] = r;
        end
    end

    // With no registers at all the block is a pass-through, so the stall comes straight from downstream.
    if (NR == 0) begin : g_adv_direct
        assign adv = out_ready;
    end else begin : g_adv_pipe
        assign adv = !out_valid || out_ready;
    end

    assign in_ready  = adv;
    assign out_valid = src[NG].valid;
    assign sum       = src[NG].sum[WIDTH-1:0];
    assign cout      = src[NG].carry;
    assign ovf       = src[NG].msb_cin ^ src[NG].carry;

    always_comb begin
        stage_unused = 1'b0;
        for (int k = 0; k <= NG; k++) begin
            stage_unused = stage_unused ^ (^src[k]);
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder (WIDTH=16, OUT_REG=1, latency 4).
module tb_pipelined_cla_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
`ifdef CLA_SUB_EN
    logic         sub;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    pipelined_cla_adder #(.WIDTH(W), .OUT_REG(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
`ifdef CLA_SUB_EN
        ,
        .sub       (sub)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_output actual sum=%0h required no result (cycle %0d)", sum, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("sum", 32'(sum), 32'(mon_e.sum));
                check("cout", 32'(cout), 32'(mon_e.cout));
                check("ovf", 32'(ovf), 32'(mon_e.ovf));
                check("latency", cyc - mon_e.acc, mon_e.lat);
            end
        end
    end

    // Presents one beat and pushes its expectation at the cycle it is accepted.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci, input logic sb,
                        input logic [W-1:0] es, input logic ec, input logic eo, input int elat);
        int   waited;
        exp_t e;
        waited = 0;
        a = av;
        b = bv;
        cin = ci;
`ifdef CLA_SUB_EN
        sub = sb;
`else
        if (sb) $display("note: sub requested without CLA_SUB_EN");
`endif
        in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 100) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual in_ready=0 required 1 within 100 cycles");
                in_valid = 1'b0;
                return;
            end
        end
        e.sum = es;
        e.cout = ec;
        e.ovf = eo;
        e.acc = cyc;
        e.lat = elat;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    logic [W-1:0] st_a   [5] = '{16'h1234, 16'h0F0F, 16'h8000, 16'hAAAA, 16'h00FF};
    logic [W-1:0] st_b   [5] = '{16'h1111, 16'h00F1, 16'h8000, 16'h5555, 16'hFF01};
    logic         st_ci  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] st_s   [5] = '{16'h2345, 16'h1000, 16'h0000, 16'h0000, 16'h0000};
    logic         st_co  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic         st_ov  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        out_ready = 1'b1;
`ifdef CLA_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4);
        idle();
        drain();

        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4);
        send(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 4);
        send(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 4);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4);
        idle();
        drain();

        for (int i = 0; i < 5; i++)
            send(st_a[i], st_b[i], st_ci[i], 1'b0, st_s[i], st_co[i], st_ov[i], 4);
        idle();
        drain();

        // Backpressure: stall 3 cycles from the moment the first result appears.
        send(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 7);
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 7);
        send(16'hFFFE, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 7);
        idle();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_out_valid", 32'(out_valid), 1);
            check("stall_sum", 32'(sum), 32'h0003);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();

        // Reset with two beats in flight, the first already presented.
        send(16'h1000, 16'h2000, 1'b0, 1'b0, 16'h3000, 1'b0, 1'b0, 4);
        send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4);
        idle();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_rst_out_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_sum", 32'(sum), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_out_valid", 32'(out_valid), 0);
        send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4);
        idle();
        drain();

`ifdef CLA_SUB_EN
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4);
        send(16'h0009, 16'h0004, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 4);
        send(16'h0009, 16'h0004, 1'b1, 1'b0, 16'h000E, 1'b0, 1'b0, 4);
        idle();
        drain();
`endif

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
